// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes and mux select codes.
// Decode helpers live here so the main FSM and any datapath glue agree on what is supported.
package riscv_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t StFetch    = 4'd0;
    localparam state_t StDecode   = 4'd1;
    localparam state_t StMemAdr   = 4'd2;
    localparam state_t StMemRead  = 4'd3;
    localparam state_t StMemWb    = 4'd4;
    localparam state_t StMemWrite = 4'd5;
    localparam state_t StExecR    = 4'd6;
    localparam state_t StExecI    = 4'd7;
    localparam state_t StAluWb    = 4'd8;
    localparam state_t StBeq      = 4'd9;
    localparam state_t StJal      = 4'd10;
    localparam state_t StLui      = 4'd11;
    localparam state_t StJalr     = 4'd12;
    localparam state_t StLink     = 4'd13;

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpLui  = 7'b0110111;
    localparam logic [6:0] OpJalr = 7'b1100111;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    function automatic logic op_supported(input logic [6:0] op, input bit en_lui,
                                          input bit en_jalr);
        case (op)
            OpLw, OpSw, OpR, OpI, OpBeq, OpJal: return 1'b1;
            OpLui:                              return en_lui;
            OpJalr:                             return en_jalr;
            default:                            return 1'b0;
        endcase
    endfunction

    // Disabled opcodes fall back to the I-type code like any other unknown op.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op, input bit en_lui);
        case (op)
            OpSw:    return ImmS;
            OpBeq:   return ImmB;
            OpJal:   return ImmJ;
            OpLui:   return en_lui ? ImmU : ImmI;
            default: return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/writeback and
// drives memory, IR, PC, ALU-mux and register-file controls each cycle.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit EN_LUI        = 1'b1,
    parameter bit EN_JALR       = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       IllegalOp,
    output logic       InstrDone
);

    state_t state_q, state_d;
    logic   ready;
    logic   pc_update;
    logic   branch;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:    state_d = ready ? StDecode : StFetch;
            StDecode: begin
                if (op_supported(op, EN_LUI, EN_JALR)) begin
                    case (op)
                        OpLw, OpSw: state_d = StMemAdr;
                        OpR:        state_d = StExecR;
                        OpI:        state_d = StExecI;
                        OpBeq:      state_d = StBeq;
                        OpJal:      state_d = StJal;
                        OpLui:      state_d = StLui;
                        OpJalr:     state_d = StJalr;
                        default:    state_d = StFetch;
                    endcase
                end
            end
            StMemAdr:   state_d = (op == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  state_d = ready ? StMemWb : StMemRead;
            StMemWrite: state_d = ready ? StFetch : StMemWrite;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StLui:      state_d = StAluWb;
            StJalr:     state_d = StLink;
            StLink:     state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = ResAluOut;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBRs2;
        ALUOp     = AluAdd;
        IllegalOp = 1'b0;
        InstrDone = 1'b0;
        case (state_q)
            StFetch: begin
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                IRWrite   = ready;
                pc_update = ready;
            end
            StDecode: begin
                ALUSrcA   = SrcAOldPc;
                ALUSrcB   = SrcBImm;
                IllegalOp = !op_supported(op, EN_LUI, EN_JALR);
            end
            StMemAdr: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
            end
            StMemRead: AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc = ResData;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                MemWrite  = ready;
                InstrDone = ready;
            end
            StExecR: begin
                ALUSrcA = SrcARs1;
                ALUOp   = AluFunct;
            end
            StExecI: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                ALUOp   = AluFunct;
            end
            StAluWb: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            StBeq: begin
                ALUSrcA   = SrcARs1;
                ALUOp     = AluSub;
                branch    = 1'b1;
                InstrDone = 1'b1;
            end
            StJal: begin
                ALUSrcA   = SrcAOldPc;
                ALUSrcB   = SrcBFour;
                pc_update = 1'b1;
            end
            StLui: begin
                ALUSrcA = SrcAZero;
                ALUSrcB = SrcBImm;
            end
            StJalr: begin
                ALUSrcA   = SrcARs1;
                ALUSrcB   = SrcBImm;
                ResultSrc = ResAluResult;
                pc_update = 1'b1;
            end
            StLink: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBFour;
            end
            default: ;
        endcase
        // Reset is asynchronous, so outputs must go quiet without waiting for a clock edge.
        if (!rst_n) begin
            pc_update = 1'b0;
            branch    = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = 2'b00;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            ALUOp     = 2'b00;
            IllegalOp = 1'b0;
            InstrDone = 1'b0;
        end
    end

    assign PCWrite = pc_update | (branch & Zero);
    assign ImmSrc  = rst_n ? imm_src_of(op, EN_LUI) : 3'b000;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scenario bench for multicycle_ctrl_fsm: a default-parameter DUT plus one with lui/jalr and the
// memory handshake disabled. Expected output words are queued with their stimulus.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, LUI = 7'b0110111;
    localparam logic [6:0] JALR = 7'b1100111, BAD = 7'b1111111;
    localparam logic [2:0] I = 3'b000, S = 3'b001, B = 3'b010, J = 3'b011, U = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n, rst2_n;
    logic [6:0] op, op2;
    logic       Zero, mem_ready;

    logic       pcw1, adr1, mw1, irw1, rw1, ill1, done1;
    logic [1:0] res1, sa1, sb1, aop1;
    logic [2:0] imm1;
    logic       pcw2, adr2, mw2, irw2, rw2, ill2, done2;
    logic [1:0] res2, sa2, sb2, aop2;
    logic [2:0] imm2;
    logic [17:0] out1, out2;

    logic [6:0]  op_q[$];
    bit          rdy_q[$];
    bit          z_q[$];
    logic [17:0] sb[$];
    int unsigned checks = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .RegWrite(rw1),
        .ResultSrc(res1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1), .ImmSrc(imm1),
        .IllegalOp(ill1), .InstrDone(done1)
    );

    multicycle_ctrl_fsm #(.EN_LUI(1'b0), .EN_JALR(1'b0), .MEM_HANDSHAKE(1'b0)) dut2 (
        .clk(clk), .rst_n(rst2_n), .op(op2), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2), .RegWrite(rw2),
        .ResultSrc(res2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ALUOp(aop2), .ImmSrc(imm2),
        .IllegalOp(ill2), .InstrDone(done2)
    );

    assign out1 = {pcw1, adr1, mw1, irw1, rw1, res1, sa1, sb1, aop1, imm1, ill1, done1};
    assign out2 = {pcw2, adr2, mw2, irw2, rw2, res2, sa2, sb2, aop2, imm2, ill2, done2};

    function automatic logic [17:0] ev(input bit pcw, adr, mw, irw, rw,
                                       input logic [1:0] res, a, b, aop,
                                       input logic [2:0] imm, input bit ill, done);
        return {pcw, adr, mw, irw, rw, res, a, b, aop, imm, ill, done};
    endfunction

    function automatic logic [17:0] fe(input bit r, input logic [2:0] imm);
        return ev(r, 0, 0, r, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0, 0);
    endfunction

    function automatic logic [17:0] de(input logic [2:0] imm, input bit ill);
        return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, ill, 0);
    endfunction

    function automatic logic [17:0] aluwb(input logic [2:0] imm);
        return ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0, 1);
    endfunction

    task automatic sched(input logic [6:0] o, input bit r, input bit z, input logic [17:0] e);
        op_q.push_back(o);
        rdy_q.push_back(r);
        z_q.push_back(z);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [17:0] e;
        int n = 0;
        rst_n = 1'b0; rst2_n = 1'b0; op = SW; op2 = LW; Zero = 1'b0; mem_ready = 1'b1;
        #3;
        checks++;
        if (out1 !== 18'd0) $display("FAIL reset_hold: got %b want %b", out1, 18'd0);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out1 !== 18'd0) $display("FAIL reset_clocked: got %b want %b", out1, 18'd0);
        else passed++;
        rst_n = 1'b1;
        sched(SW, 1, 0, fe(1, S));
        sched(SW, 1, 0, de(S, 0));
        sched(SW, 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, S, 0, 0));
        sched(SW, 1, 0, ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, S, 0, 1));
        while (sb.size() != 0) begin
            @(negedge clk);
            op = op_q.pop_front(); mem_ready = rdy_q.pop_front(); Zero = z_q.pop_front();
            #2;
            e = sb.pop_front();
            checks++;
            if (out1 !== e) $display("FAIL reset_sw cyc %0d: got %b want %b", n, out1, e);
            else passed++;
            n++;
        end
        // Drop reset in the middle of the MEMWRITE cycle.
        rst_n = 1'b0;
        #1;
        checks++;
        if (out1 !== 18'd0) $display("FAIL reset_midwrite: got %b want %b", out1, 18'd0);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (out1 !== 18'd0) $display("FAIL reset_edge: got %b want %b", out1, 18'd0);
        else passed++;
        rst_n = 1'b1;
        sched(SW, 1, 0, fe(1, S));
        sched(SW, 1, 0, de(S, 0));
        sched(SW, 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, S, 0, 0));
        sched(SW, 1, 0, ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, S, 0, 1));
        while (sb.size() != 0) begin
            @(negedge clk);
            op = op_q.pop_front(); mem_ready = rdy_q.pop_front(); Zero = z_q.pop_front();
            #2;
            e = sb.pop_front();
            checks++;
            if (out1 !== e) $display("FAIL reset_resume cyc %0d: got %b want %b", n, out1, e);
            else passed++;
            n++;
        end
    endtask

    task automatic test_lw();
        logic [17:0] e;
        int n = 0;
        sched(LW, 1, 0, fe(1, I));
        sched(LW, 1, 0, de(I, 0));
        sched(LW, 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, I, 0, 0));
        sched(LW, 1, 0, ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, I, 0, 0));
        sched(LW, 1, 0, ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, I, 0, 1));
        while (sb.size() != 0) begin
            @(negedge clk);
            op = op_q.pop_front(); mem_ready = rdy_q.pop_front(); Zero = z_q.pop_front();
            #2;
            e = sb.pop_front();
            checks++;
            if (out1 !== e) $display("FAIL lw cyc %0d: got %b want %b", n, out1, e);
            else passed++;
            n++;
        end
    endtask

    task automatic test_fetch_wait();
        logic [17:0] e;
        int n = 0;
        sched(LW, 0, 1, fe(0, I));
        sched(LW, 0, 1, fe(0, I));
        sched(LW, 1, 1, fe(1, I));
        sched(LW, 0, 1, de(I, 0));
        sched(LW, 0, 1, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, I, 0, 0));
        sched(LW, 0, 1, ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, I, 0, 0));
        sched(LW, 1, 1, ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, I, 0, 0));
        sched(LW, 0, 1, ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, I, 0, 1));
        while (sb.size() != 0) begin
            @(negedge clk);
            op = op_q.pop_front(); mem_ready = rdy_q.pop_front(); Zero = z_q.pop_front();
            #2;
            e = sb.pop_front();
            checks++;
            if (out1 !== e) $display("FAIL lw_wait cyc %0d: got %b want %b", n, out1, e);
            else passed++;
            n++;
        end
    endtask

    task automatic test_sw_wait();
        logic [17:0] e;
        int n = 0;
        sched(SW, 1, 0, fe(1, S));
        sched(SW, 0, 0, de(S, 0));
        sched(SW, 0, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, S, 0, 0));
        for (int k = 0; k < 3; k++)
            sched(SW, 0, 0, ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, S, 0, 0));
        sched(SW, 1, 0, ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, S, 0, 1));
        while (sb.size() != 0) begin
            @(negedge clk);
            op = op_q.pop_front(); mem_ready = rdy_q.pop_front(); Zero = z_q.pop_front();
            #2;
            e = sb.pop_front();
            checks++;
            if (out1 !== e) $display("FAIL sw_wait cyc %0d: got %b want %b", n, out1, e);
            else passed++;
            n++;
        end
    endtask

    task automatic test_beq();
        logic [17:0] e;
        int n = 0;
        sched(BEQ, 0, 1, fe(0, B));
        sched(BEQ, 1, 1, fe(1, B));
        sched(BEQ, 1, 1, de(B, 0));
        sched(BEQ, 1, 1, ev(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, B, 0, 1));
        sched(BEQ, 1, 0, fe(1, B));
        sched(BEQ, 1, 0, de(B, 0));
        sched(BEQ, 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, B, 0, 1));
        while (sb.size() != 0) begin
            @(negedge clk);
            op = op_q.pop_front(); mem_ready = rdy_q.pop_front(); Zero = z_q.pop_front();
            #2;
            e = sb.pop_front();
            checks++;
            if (out1 !== e) $display("FAIL beq cyc %0d: got %b want %b", n, out1, e);
            else passed++;
            n++;
        end
    endtask

    task automatic test_jalr();
        logic [17:0] e;
        int n = 0;
        sched(JALR, 1, 0, fe(1, I));
        sched(JALR, 1, 0, de(I, 0));
        sched(JALR, 1, 0, ev(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 2'b00, I, 0, 0));
        sched(JALR, 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, I, 0, 0));
        sched(JALR, 1, 0, aluwb(I));
        while (sb.size() != 0) begin
            @(negedge clk);
            op = op_q.pop_front(); mem_ready = rdy_q.pop_front(); Zero = z_q.pop_front();
            #2;
            e = sb.pop_front();
            checks++;
            if (out1 !== e) $display("FAIL jalr cyc %0d: got %b want %b", n, out1, e);
            else passed++;
            n++;
        end
    endtask

    task automatic test_illegal();
        logic [17:0] e;
        int n = 0;
        for (int k = 0; k < 2; k++) begin
            sched(BAD, 1, 0, fe(1, I));
            sched(BAD, 1, 0, de(I, 1));
        end
        while (sb.size() != 0) begin
            @(negedge clk);
            op = op_q.pop_front(); mem_ready = rdy_q.pop_front(); Zero = z_q.pop_front();
            #2;
            e = sb.pop_front();
            checks++;
            if (out1 !== e) $display("FAIL illegal cyc %0d: got %b want %b", n, out1, e);
            else passed++;
            n++;
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        int n = 0;
        sched(RT, 1, 0, fe(1, I));
        sched(RT, 1, 0, de(I, 0));
        sched(RT, 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, I, 0, 0));
        sched(RT, 1, 0, aluwb(I));
        sched(IT, 1, 0, fe(1, I));
        sched(IT, 1, 0, de(I, 0));
        sched(IT, 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, I, 0, 0));
        sched(IT, 1, 0, aluwb(I));
        sched(JAL, 1, 0, fe(1, J));
        sched(JAL, 1, 0, de(J, 0));
        sched(JAL, 1, 0, ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, J, 0, 0));
        sched(JAL, 1, 0, aluwb(J));
        sched(LUI, 1, 0, fe(1, U));
        sched(LUI, 1, 0, de(U, 0));
        sched(LUI, 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, U, 0, 0));
        sched(LUI, 1, 0, aluwb(U));
        while (sb.size() != 0) begin
            @(negedge clk);
            op = op_q.pop_front(); mem_ready = rdy_q.pop_front(); Zero = z_q.pop_front();
            #2;
            e = sb.pop_front();
            checks++;
            if (out1 !== e) $display("FAIL back_to_back cyc %0d: got %b want %b", n, out1, e);
            else passed++;
            n++;
        end
    endtask

    task automatic test_params();
        logic [17:0] e;
        int n = 0;
        #1;
        checks++;
        if (out2 !== 18'd0) $display("FAIL params_reset: got %b want %b", out2, 18'd0);
        else passed++;
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        sched(JALR, 1, 0, fe(1, I));
        sched(JALR, 1, 0, de(I, 1));
        sched(LUI, 1, 0, fe(1, I));
        sched(LUI, 1, 0, de(I, 1));
        sched(LW, 0, 0, fe(1, I));
        sched(LW, 0, 0, de(I, 0));
        sched(LW, 0, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, I, 0, 0));
        sched(LW, 0, 0, ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, I, 0, 0));
        sched(LW, 0, 0, ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, I, 0, 1));
        sched(SW, 0, 0, fe(1, S));
        sched(SW, 0, 0, de(S, 0));
        sched(SW, 0, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, S, 0, 0));
        sched(SW, 0, 0, ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, S, 0, 1));
        while (sb.size() != 0) begin
            @(negedge clk);
            op2 = op_q.pop_front(); mem_ready = rdy_q.pop_front(); Zero = z_q.pop_front();
            #2;
            e = sb.pop_front();
            checks++;
            if (out2 !== e) $display("FAIL params cyc %0d: got %b want %b", n, out2, e);
            else passed++;
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at time %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_fetch_wait();
        test_sw_wait();
        test_beq();
        test_jalr();
        test_illegal();
        test_back_to_back();
        test_params();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
